// File: rtl/ram_wb_arbiter_if.sv
// Wishbone link between one SoC-side master and the RAM arbiter.
// The master modport drives the request; the slave modport returns data and completion.
interface ram_wb_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (output cyc, stb, we, addr, wdata, input rdata, ack, err);
   modport slave  (input cyc, stb, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/ram_wb_arbiter.sv
// Round-robin arbiter sharing the wishbone backdoor of a 4002-style RAM bank between two masters.
// Define HALT_ON_ACCESS_EN to raise halt_o while a chip access is in flight.
module ram_wb_arbiter #(
   parameter int unsigned NUM_CHIPS = 4,
   parameter int unsigned TIMEOUT   = 12
) (
   input  logic                    clock,
   input  logic                    reset_n,
   ram_wb_arbiter_if.slave         m0,
   ram_wb_arbiter_if.slave         m1,
   output logic [NUM_CHIPS-1:0]    s_cyc_o,
   output logic [NUM_CHIPS-1:0]    s_stb_o,
   output logic                    s_we_o,
   output logic [31:0]             s_addr_o,
   output logic [31:0]             s_data_o,
   input  logic [32*NUM_CHIPS-1:0] s_data_i,
   input  logic [NUM_CHIPS-1:0]    s_ack_i,
   output logic                    halt_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant_q, grant_d;
   logic                  we_q, we_d;
   logic [8:0]            addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [NUM_CHIPS-1:0]  stb_q, stb_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;

   logic                  req0, req1, pick1;
   logic                  sel_we, chip_ok, start_access, chip_ack;
   logic [10:0]           sel_addr;
   logic [31:0]           sel_wdata, chip_rdata;
   logic [1:0]            sel_chip;
   logic                  unused_addr_bits;

   assign req0 = m0.cyc & m0.stb;
   assign req1 = m1.cyc & m1.stb;
   // On a tie the master that was not granted last wins.
   assign pick1 = req1 & (~req0 | ~last_grant_q);

   assign sel_we    = pick1 ? m1.we          : m0.we;
   assign sel_addr  = pick1 ? m1.addr[10:0]  : m0.addr[10:0];
   assign sel_wdata = pick1 ? m1.wdata       : m0.wdata;
   assign sel_chip  = sel_addr[10:9];
   assign chip_ok   = 32'(sel_chip) < NUM_CHIPS;

   assign unused_addr_bits = ^{m0.addr[31:11], m1.addr[31:11]};

   // stb_q is one-hot on the selected chip, so it also masks foreign acks.
   assign chip_ack = |(s_ack_i & stb_q);

   always_comb begin
      chip_rdata = '0;
      for (int k = 0; k < NUM_CHIPS; k++) begin
         if (stb_q[k]) chip_rdata = s_data_i[32*k +: 32];
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      stb_d        = stb_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      start_access = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req0 | req1) begin
               grant_d      = pick1;
               last_grant_d = pick1;
               we_d         = sel_we;
               addr_d       = sel_addr[8:0];
               wdata_d      = sel_wdata;
               cnt_d        = '0;
               if (chip_ok) begin
                  for (int k = 0; k < NUM_CHIPS; k++) stb_d[k] = (sel_chip == k[1:0]);
                  start_access = 1'b1;
                  state_d      = StBusy;
               end else begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StBusy: begin
            if (chip_ack) begin
               rdata_d = chip_rdata;
               stb_d   = '0;
               ack_d   = 1'b1;
               state_d = StResp;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               rdata_d = '0;
               stb_d   = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         stb_q        <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         stb_q        <= stb_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
      end
   end

   assign s_cyc_o  = stb_q;
   assign s_stb_o  = stb_q;
   assign s_we_o   = we_q;
   assign s_addr_o = {23'h0, addr_q};
   assign s_data_o = wdata_q;

   assign m0.ack   = ack_q & ~grant_q;
   assign m0.err   = err_q & ~grant_q;
   assign m0.rdata = (ack_q & ~grant_q) ? rdata_q : '0;
   assign m1.ack   = ack_q & grant_q;
   assign m1.err   = err_q & grant_q;
   assign m1.rdata = (ack_q & grant_q) ? rdata_q : '0;

`ifdef HALT_ON_ACCESS_EN
   logic halt_q, halt_d;

   // Raised with the strobe, dropped on entry to the response cycle.
   always_comb begin
      halt_d = halt_q;
      if (start_access) begin
         halt_d = 1'b1;
      end else if (state_d == StResp) begin
         halt_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
      end
   end

   assign halt_o = halt_q;
`else
   logic unused_start_access;
   assign unused_start_access = start_access;
   assign halt_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Randomised bench for ram_wb_arbiter: chip bank model plus a reference memory and grant-order model.
// Honours HALT_ON_ACCESS_EN in the chip model and in the halt checks.
module tb_ram_wb_arbiter;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ram_wb_arbiter_if m0_if ();
   ram_wb_arbiter_if m1_if ();
   ram_wb_arbiter_if m0b_if ();
   ram_wb_arbiter_if m1b_if ();

   logic [3:0]   s_cyc, s_stb, s_ack;
   logic         s_we, halt;
   logic [31:0]  s_addr, s_data;
   logic [127:0] s_rdata;
   logic [1:0]   b_cyc, b_stb;
   logic         b_we, b_halt;
   logic [31:0]  b_addr, b_data;

   ram_wb_arbiter #(.NUM_CHIPS(4), .TIMEOUT(12)) dut (
      .clock(clock), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_data),
      .s_data_i(s_rdata), .s_ack_i(s_ack), .halt_o(halt)
   );

   ram_wb_arbiter #(.NUM_CHIPS(2), .TIMEOUT(12)) dut_b (
      .clock(clock), .reset_n(reset_n), .m0(m0b_if), .m1(m1b_if),
      .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_we_o(b_we), .s_addr_o(b_addr), .s_data_o(b_data),
      .s_data_i(64'h0), .s_ack_i(2'b00), .halt_o(b_halt)
   );

   // Chip bank: ack one cycle after strobe when ready, never twice in a row.
   bit [31:0] mem [4][512];
   logic [2:0] phase;
   bit mute = 1'b0;
   logic chip_ready;
`ifdef HALT_ON_ACCESS_EN
   assign chip_ready = 1'b1;
`else
   assign chip_ready = (phase == 3'd7);
`endif

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
         s_ack <= '0;
      end else begin
         phase <= phase + 3'd1;
         for (int k = 0; k < 4; k++) begin
            if (s_stb[k] && !s_ack[k] && !mute && chip_ready) begin
               s_ack[k] <= 1'b1;
               if (s_we) mem[k][s_addr[8:0]] <= s_data;
            end else begin
               s_ack[k] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      s_rdata = '0;
      for (int k = 0; k < 4; k++) s_rdata[32*k +: 32] = mem[k][s_addr[8:0]];
   end

   // Reference model state.
   bit [31:0] ref_mem [2048];
   bit        ref_last;
   int        n_checks = 0;
   int        n_fail = 0;

   // Monitors: monotonic counters, tests take differences.
   int done_q[$];
   int stb_other_cnt = 0, stb0_cnt = 0, halt_cnt = 0, b_sel_cnt = 0, b_halt_cnt = 0;
   int m0_ack_cnt = 0, m1_resp_cnt = 0;
   always @(negedge clock) begin
      if (m0_if.ack || m0_if.err) done_q.push_back(0);
      if (m1_if.ack || m1_if.err) done_q.push_back(1);
      if (m0_if.ack) m0_ack_cnt <= m0_ack_cnt + 1;
      if (m1_if.ack || m1_if.err) m1_resp_cnt <= m1_resp_cnt + 1;
      if (s_stb != 4'b0000 && s_stb != 4'b0010) stb_other_cnt <= stb_other_cnt + 1;
      if (s_stb[0]) stb0_cnt <= stb0_cnt + 1;
      if (halt) halt_cnt <= halt_cnt + 1;
      if (b_cyc != 2'b00 || b_stb != 2'b00) b_sel_cnt <= b_sel_cnt + 1;
      if (b_halt) b_halt_cnt <= b_halt_cnt + 1;
   end

   task automatic drive(input int m, input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] data);
      case (m)
         0: begin m0_if.cyc = req; m0_if.stb = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = data; end
         1: begin m1_if.cyc = req; m1_if.stb = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = data; end
         default: begin
            m0b_if.cyc = req; m0b_if.stb = req; m0b_if.we = we; m0b_if.addr = addr; m0b_if.wdata = data;
         end
      endcase
   endtask

   function automatic logic [33:0] resp(input int m);
      case (m)
         0:       return {m0_if.ack, m0_if.err, m0_if.rdata};
         1:       return {m1_if.ack, m1_if.err, m1_if.rdata};
         default: return {m0b_if.ack, m0b_if.err, m0b_if.rdata};
      endcase
   endfunction

   // One master transaction; lat counts clock edges from the grant edge (=1) to the response.
   task automatic access(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output bit ack, output bit err, output int lat);
      logic [33:0] r;
      ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
      @(negedge clock);
      drive(m, 1'b1, we, addr, wd);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         r = resp(m);
         if (r[33] || r[32]) begin
            ack = r[33]; err = r[32]; rd = r[31:0]; lat = i;
            break;
         end
      end
      drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      ref_last = 1'b1;
   endtask

   function automatic logic [31:0] make_addr(input int chip, input int word);
      logic [31:0] a;
      a = $urandom();
      a[10:9] = 2'(chip);
      a[8:0]  = 9'(word);
      return a;
   endfunction

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({s_cyc, s_stb} !== 8'h0) begin
         n_fail++; $display("FAIL reset_sel: got %h required 00", {s_cyc, s_stb});
      end
      n_checks++;
      if ({s_we, s_addr, s_data} !== 65'h0) begin
         n_fail++; $display("FAIL reset_bus: got %h required 0", {s_we, s_addr, s_data});
      end
      n_checks++;
      if ({m0_if.ack, m0_if.err, m0_if.rdata, m1_if.ack, m1_if.err, m1_if.rdata} !== 68'h0) begin
         n_fail++; $display("FAIL reset_master: got nonzero master response, required 0");
      end
      n_checks++;
      if ({halt, b_halt, b_cyc, b_stb} !== 6'h0) begin
         n_fail++; $display("FAIL reset_halt: got %b required 0", {halt, b_halt, b_cyc, b_stb});
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; bit ak, er; int lt;
      int so, ac;
      so = stb_other_cnt; ac = m0_ack_cnt;
      access(0, 1'b1, 32'h0000_0204, 32'h9, rd, ak, er, lt);
      ref_mem[512 + 4] = 32'h9;
      n_checks++;
      if ({ak, er} !== 2'b10) begin
         n_fail++; $display("FAIL wr_resp: got ack/err %b%b required 10", ak, er);
      end
      n_checks++;
      if (lt < 3 || lt > 10) begin
         n_fail++; $display("FAIL wr_latency: got %0d required 3..10", lt);
      end
      access(0, 1'b0, 32'h0000_0204, 32'h0, rd, ak, er, lt);
      n_checks++;
      if ({ak, er} !== 2'b10 || rd !== ref_mem[512 + 4]) begin
         n_fail++; $display("FAIL rd_data: got ack/err %b%b data %h required 10 %h", ak, er, rd,
                            ref_mem[512 + 4]);
      end
      repeat (2) @(negedge clock);
      #1;
      n_checks++;
      if (m0_ack_cnt - ac !== 2) begin
         n_fail++; $display("FAIL wr_rd_pulses: got %0d ack pulses required 2", m0_ack_cnt - ac);
      end
      n_checks++;
      if (stb_other_cnt - so !== 0) begin
         n_fail++; $display("FAIL wr_rd_stb: got %0d cycles with s_stb other than 0010 required 0",
                            stb_other_cnt - so);
      end
   endtask

   task automatic test_arbitration();
      logic [31:0] a0, a1, d0, d1, rd0, rd1;
      bit ak0, er0, ak1, er1, we;
      int lt0, lt1, i0, i1, exp_first;
      do_reset();
      a0 = '0; a1 = '0; i0 = 0; i1 = 0;
      for (int r = 0; r < 4; r++) begin
         we = (r % 2 == 0);
         if (we) begin
            i0 = $urandom_range(0, 1) * 512 + $urandom_range(0, 511);
            i1 = $urandom_range(2, 3) * 512 + $urandom_range(0, 511);
            a0 = make_addr(i0 / 512, i0 % 512);
            a1 = make_addr(i1 / 512, i1 % 512);
         end
         d0 = $urandom(); d1 = $urandom();
         exp_first = ref_last ? 0 : 1;
         done_q.delete();
         fork
            access(0, we, a0, d0, rd0, ak0, er0, lt0);
            access(1, we, a1, d1, rd1, ak1, er1, lt1);
         join
         @(negedge clock); #1;
         n_checks++;
         if (done_q.size() != 2 || done_q[0] != exp_first || done_q[1] != 1 - exp_first) begin
            n_fail++; $display("FAIL arb_order round %0d: got %0d completions first m%0d required m%0d then m%0d",
                               r, done_q.size(), done_q.size() > 0 ? done_q[0] : -1, exp_first,
                               1 - exp_first);
         end
         ref_last = 1'(1 - exp_first);
         n_checks++;
         if ({ak0, er0, ak1, er1} !== 4'b1010) begin
            n_fail++; $display("FAIL arb_resp round %0d: got %b required 1010", r, {ak0, er0, ak1, er1});
         end
         if (we) begin
            ref_mem[i0] = d0;
            ref_mem[i1] = d1;
         end else begin
            n_checks++;
            if (rd0 !== ref_mem[i0] || rd1 !== ref_mem[i1]) begin
               n_fail++; $display("FAIL arb_rdata round %0d: got %h %h required %h %h", r, rd0, rd1,
                                  ref_mem[i0], ref_mem[i1]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd; bit ak, er; int lt, s0;
      mute = 1'b1;
      s0 = stb0_cnt;
      access(0, 1'b0, 32'h0000_0010, 32'h0, rd, ak, er, lt);
      mute = 1'b0;
      n_checks++;
      if ({ak, er} !== 2'b01 || rd !== 32'h0) begin
         n_fail++; $display("FAIL timeout_resp: got ack/err %b%b data %h required 01 0", ak, er, rd);
      end
      n_checks++;
      if (stb0_cnt - s0 !== 12) begin
         n_fail++; $display("FAIL timeout_stb_cycles: got %0d required 12", stb0_cnt - s0);
      end
      n_checks++;
      if (lt !== 13) begin
         n_fail++; $display("FAIL timeout_latency: got %0d required 13", lt);
      end
   endtask

   task automatic test_bad_chip();
      logic [31:0] rd; bit ak, er; int lt, bs, bh;
      bs = b_sel_cnt; bh = b_halt_cnt;
      access(2, 1'b0, 32'h0000_0600, 32'h0, rd, ak, er, lt);
      repeat (2) @(negedge clock); #1;
      n_checks++;
      if ({ak, er} !== 2'b01 || rd !== 32'h0) begin
         n_fail++; $display("FAIL badchip_resp: got ack/err %b%b data %h required 01 0", ak, er, rd);
      end
      n_checks++;
      if (b_sel_cnt - bs !== 0) begin
         n_fail++; $display("FAIL badchip_select: got %0d selected cycles required 0", b_sel_cnt - bs);
      end
      n_checks++;
      if (b_halt_cnt - bh !== 0) begin
         n_fail++; $display("FAIL badchip_halt: got %0d halt cycles required 0", b_halt_cnt - bh);
      end
   endtask

   task automatic test_halt();
      logic [31:0] rd; bit ak, er; int lt, h0;
      h0 = halt_cnt;
      access(0, 1'b0, 32'h0000_0104, 32'h0, rd, ak, er, lt);
      n_checks++;
      if ({ak, er} !== 2'b10 || rd !== ref_mem[32'h104]) begin
         n_fail++; $display("FAIL halt_rdata: got ack/err %b%b data %h required 10 %h", ak, er, rd,
                            ref_mem[32'h104]);
      end
`ifdef HALT_ON_ACCESS_EN
      n_checks++;
      if (halt_cnt - h0 !== 2) begin
         n_fail++; $display("FAIL halt_cycles: got %0d required 2", halt_cnt - h0);
      end
      n_checks++;
      if (lt !== 3) begin
         n_fail++; $display("FAIL halt_latency: got %0d required 3", lt);
      end
`else
      n_checks++;
      if (halt_cnt - h0 !== 0) begin
         n_fail++; $display("FAIL halt_cycles: got %0d required 0", halt_cnt - h0);
      end
      n_checks++;
      if (lt < 3 || lt > 10) begin
         n_fail++; $display("FAIL halt_latency: got %0d required 3..10", lt);
      end
`endif
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] rd; bit ak, er; int lt;
      mute = 1'b1;
      @(negedge clock);
      drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      repeat (3) @(posedge clock);
      #2;
      n_checks++;
      if (s_stb !== 4'b0001) begin
         n_fail++; $display("FAIL midbusy_active: got s_stb %b required 0001", s_stb);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({s_cyc, s_stb, s_we, s_addr, s_data, halt, m0_if.ack, m0_if.err, m0_if.rdata,
           m1_if.ack, m1_if.err, m1_if.rdata} !== '0) begin
         n_fail++; $display("FAIL midbusy_reset: got stb %b addr %h halt %b required all 0", s_stb,
                            s_addr, halt);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      mute = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      ref_last = 1'b1;
      access(0, 1'b0, 32'h0000_0204, 32'h0, rd, ak, er, lt);
      n_checks++;
      if ({ak, er} !== 2'b10 || rd !== ref_mem[512 + 4]) begin
         n_fail++; $display("FAIL midbusy_after: got ack/err %b%b data %h required 10 %h", ak, er, rd,
                            ref_mem[512 + 4]);
      end
   endtask

   initial begin
      for (int m = 0; m < 3; m++) drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
      m1b_if.cyc = 1'b0; m1b_if.stb = 1'b0; m1b_if.we = 1'b0;
      m1b_if.addr = 32'h0; m1b_if.wdata = 32'h0;
      test_reset();
      test_write_read();
      test_arbitration();
      test_timeout();
      test_bad_chip();
      test_halt();
      test_reset_mid_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
